dwc_recovery_ctrl: RTL and testbench

- Receiving end of a duplication-with-comparison (DwC) datapath.
- Accepts the two redundant registered copies of a result from a duplicated producer and compares them.
- On match, forwards one copy downstream over a valid/ready handshake.
- On mismatch, flags a transient error, asks the producer to recompute, and after too many consecutive mismatches on one item latches a sticky fatal fault until cleared.

---
 rtl/dwc_pkg.sv | 14 +
 rtl/dwc_compare.sv | 12 +
 rtl/dwc_recovery_ctrl.sv | 97 +++++++++
 tb/tb_dwc_recovery_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/dwc_pkg.sv
// Shared types and default constants for duplication-with-comparison blocks.
package dwc_pkg;

    typedef enum logic [1:0] {
        ST_ACCEPT,
        ST_RETRY,
        ST_HOLD,
        ST_FATAL
    } dwc_state_t;

    localparam int DWC_MAX_RETRY = 3;
    localparam int DWC_ERR_CNT_W = 8;

endpackage

// File: rtl/dwc_compare.sv
// Combinational equality check of two redundant copies.
module dwc_compare #(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] copy_a,
    input  logic [WIDTH-1:0] copy_b,
    output logic             match
);

    assign match = &(~(copy_a ^ copy_b));

endmodule

// File: rtl/dwc_recovery_ctrl.sv
// DwC receiver: compares redundant copies, forwards matches, requests recompute on
// mismatch, and latches a sticky fatal fault after too many consecutive mismatches.
module dwc_recovery_ctrl
    import dwc_pkg::*;
#(
    parameter int WIDTH     = 1,
    parameter int MAX_RETRY = DWC_MAX_RETRY,
    parameter int ERR_CNT_W = DWC_ERR_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 port_in_valid,
    input  logic [WIDTH-1:0]     port_in_0,
    input  logic [WIDTH-1:0]     port_in_1,
    output logic                 port_in_ready,
    output logic                 port_retry,
    output logic                 port_out_valid,
    output logic [WIDTH-1:0]     port_out,
    input  logic                 port_out_ready,
    output logic                 port_error,
    output logic                 port_fatal,
    output logic [ERR_CNT_W-1:0] port_err_count,
    input  logic                 port_clear_fatal
);

    localparam int RC_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [RC_W-1:0] RC_MAX = RC_W'(MAX_RETRY);

    dwc_state_t           state;
    logic [RC_W-1:0]      retry_cnt;
    logic [ERR_CNT_W-1:0] err_count;
    logic                 match;

    dwc_compare #(
        .WIDTH (WIDTH)
    ) u_compare (
        .copy_a (port_in_0),
        .copy_b (port_in_1),
        .match  (match)
    );

    // Ready is a state decode, gated off while reset is held so nothing is taken.
    assign port_in_ready  = rst_n && (state == ST_ACCEPT);
    assign port_out_valid = (state == ST_HOLD);
    assign port_fatal     = (state == ST_FATAL);
    assign port_err_count = err_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_ACCEPT;
            retry_cnt  <= '0;
            err_count  <= '0;
            port_out   <= '0;
            port_retry <= 1'b0;
            port_error <= 1'b0;
        end else begin
            port_retry <= 1'b0;
            port_error <= 1'b0;
            case (state)
                ST_ACCEPT: begin
                    if (port_in_valid) begin
                        if (match) begin
                            port_out  <= port_in_0;
                            retry_cnt <= '0;
                            state     <= ST_HOLD;
                        end else begin
                            port_error <= 1'b1;
                            if (err_count != '1)
                                err_count <= err_count + ERR_CNT_W'(1);
                            // retry_cnt is kept on fatal; clearing the fault resets it.
                            if (retry_cnt == RC_MAX) begin
                                state <= ST_FATAL;
                            end else begin
                                retry_cnt  <= retry_cnt + RC_W'(1);
                                port_retry <= 1'b1;
                                state      <= ST_RETRY;
                            end
                        end
                    end
                end
                ST_RETRY: state <= ST_ACCEPT;
                ST_HOLD: begin
                    if (port_out_ready)
                        state <= ST_ACCEPT;
                end
                ST_FATAL: begin
                    if (port_clear_fatal) begin
                        retry_cnt <= '0;
                        state     <= ST_ACCEPT;
                    end
                end
                default: state <= ST_ACCEPT;
            endcase
        end
    end

endmodule

// File: tb/tb_dwc_recovery_ctrl.sv
// Directed bench for dwc_recovery_ctrl; a second instance with a 2-bit counter checks saturation.
module tb_dwc_recovery_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [0:0] in_0;
    logic [0:0] in_1;
    logic       out_ready;
    logic       clear_fatal;

    logic       in_ready, retry, out_valid, error, fatal;
    logic [0:0] out;
    logic [7:0] err_count;

    logic       s_in_ready, s_retry, s_out_valid, s_error, s_fatal;
    logic [0:0] s_out;
    logic [1:0] s_err_count;

    int n_checks = 0;
    int n_pass   = 0;
    int n_retry  = 0;
    int n_error  = 0;

    always #5 clk = ~clk;

    dwc_recovery_ctrl #(.WIDTH(1), .MAX_RETRY(3), .ERR_CNT_W(8)) u_dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .port_in_valid    (in_valid),
        .port_in_0        (in_0),
        .port_in_1        (in_1),
        .port_in_ready    (in_ready),
        .port_retry       (retry),
        .port_out_valid   (out_valid),
        .port_out         (out),
        .port_out_ready   (out_ready),
        .port_error       (error),
        .port_fatal       (fatal),
        .port_err_count   (err_count),
        .port_clear_fatal (clear_fatal)
    );

    dwc_recovery_ctrl #(.WIDTH(1), .MAX_RETRY(3), .ERR_CNT_W(2)) u_sat (
        .clk              (clk),
        .rst_n            (rst_n),
        .port_in_valid    (in_valid),
        .port_in_0        (in_0),
        .port_in_1        (in_1),
        .port_in_ready    (s_in_ready),
        .port_retry       (s_retry),
        .port_out_valid   (s_out_valid),
        .port_out         (s_out),
        .port_out_ready   (out_ready),
        .port_error       (s_error),
        .port_fatal       (s_fatal),
        .port_err_count   (s_err_count),
        .port_clear_fatal (clear_fatal)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_0 = '0; in_1 = '0;
        out_ready = 1'b1; clear_fatal = 1'b0;
        tick();
        tick();
        chk("rst_in_ready",  32'(in_ready), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out",       32'(out), 0);
        chk("rst_retry",     32'(retry), 0);
        chk("rst_error",     32'(error), 0);
        chk("rst_fatal",     32'(fatal), 0);
        chk("rst_count",     32'(err_count), 0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_ready", 32'(in_ready), 1);

        // Matched pair (1,1) with consumer ready
        in_valid = 1'b1; in_0 = 1'b1; in_1 = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("t1_out_valid", 32'(out_valid), 1);
        chk("t1_out",       32'(out), 1);
        chk("t1_in_ready",  32'(in_ready), 0);
        tick();
        chk("t1_out_valid_drop", 32'(out_valid), 0);
        chk("t1_in_ready_back",  32'(in_ready), 1);
        chk("t1_count",          32'(err_count), 0);

        // Mismatch (1,0) then match (1,1)
        in_valid = 1'b1; in_0 = 1'b1; in_1 = 1'b0;
        tick();
        in_1 = 1'b1;
        chk("t2_error",    32'(error), 1);
        chk("t2_retry",    32'(retry), 1);
        chk("t2_in_ready", 32'(in_ready), 0);
        chk("t2_count",    32'(err_count), 1);
        tick();
        chk("t2_error_1cyc", 32'(error), 0);
        chk("t2_retry_1cyc", 32'(retry), 0);
        chk("t2_ready_back", 32'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        chk("t2_out_valid", 32'(out_valid), 1);
        chk("t2_out",       32'(out), 1);
        tick();
        chk("t2_count_keep", 32'(err_count), 1);

        // Four consecutive mismatches reach FATAL (counter was 1 before)
        in_valid = 1'b1; in_0 = 1'b0; in_1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (error) n_error++;
            if (retry) n_retry++;
            chk($sformatf("t3_error_%0d", i), 32'(error), 1);
            chk($sformatf("t3_retry_%0d", i), 32'(retry), (i < 3) ? 1 : 0);
            chk($sformatf("t3_count_%0d", i), 32'(err_count), 2 + i);
            chk($sformatf("t3_sat_%0d", i), 32'(s_err_count), (i == 0) ? 2 : 3);
            chk($sformatf("t3_s_error_%0d", i), 32'(s_error), 1);
            if (i < 3) begin
                tick();
                chk($sformatf("t3_ready_%0d", i), 32'(in_ready), 1);
            end
        end
        in_valid = 1'b0;
        chk("t3_n_error", 32'(n_error), 4);
        chk("t3_n_retry", 32'(n_retry), 3);
        chk("t3_fatal",   32'(fatal), 1);
        chk("t3_ready",   32'(in_ready), 0);
        tick();
        tick();
        tick();
        chk("t3_fatal_sticky", 32'(fatal), 1);
        chk("t3_error_quiet",  32'(error), 0);
        chk("t3_out_valid",    32'(out_valid), 0);

        // Clear with a valid pair present: pair must be dropped
        clear_fatal = 1'b1; in_valid = 1'b1; in_0 = 1'b1; in_1 = 1'b1;
        tick();
        clear_fatal = 1'b0; in_valid = 1'b0;
        chk("t4_fatal",     32'(fatal), 0);
        chk("t4_in_ready",  32'(in_ready), 1);
        chk("t4_out_valid", 32'(out_valid), 0);
        chk("t4_count",     32'(err_count), 5);
        tick();
        chk("t4_not_taken", 32'(out_valid), 0);

        // Retry counter restarted by clear: one mismatch only retries
        in_valid = 1'b1; in_0 = 1'b1; in_1 = 1'b0;
        tick();
        in_valid = 1'b0;
        chk("t4_retry_after_clear", 32'(retry), 1);
        chk("t4_no_refatal",        32'(fatal), 0);
        chk("t4_count2",            32'(err_count), 6);
        chk("t4_sat_hold",          32'(s_err_count), 3);
        chk("t4_s_error",           32'(s_error), 1);
        tick();

        // Held output with consumer stalled, then reset mid-HOLD
        out_ready = 1'b0;
        in_valid = 1'b1; in_0 = 1'b1; in_1 = 1'b1;
        tick();
        in_valid = 1'b0; in_0 = 1'b0; in_1 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t5_valid_%0d", i), 32'(out_valid), 1);
            chk($sformatf("t5_out_%0d", i),   32'(out), 1);
            chk($sformatf("t5_ready_%0d", i), 32'(in_ready), 0);
            tick();
        end
        rst_n = 1'b0;
        #1;
        chk("t5_ready_in_rst", 32'(in_ready), 0);
        tick();
        chk("t5_rst_valid", 32'(out_valid), 0);
        chk("t5_rst_out",   32'(out), 0);
        chk("t5_rst_count", 32'(err_count), 0);
        chk("t5_rst_sat",   32'(s_err_count), 0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("t5_ready_after", 32'(in_ready), 1);

        // Matched zero pair passes through, then released
        in_valid = 1'b1; in_0 = 1'b0; in_1 = 1'b0;
        tick();
        in_valid = 1'b0;
        chk("t6_out_valid", 32'(out_valid), 1);
        chk("t6_out",       32'(out), 0);
        tick();
        chk("t6_released",  32'(in_ready), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
